debounce_edge_detect: RTL and testbench
=======================================

DEBOUNCE_EDGE_DETECT -- requirements
Module: debounce_edge_detect

Interface
REQ-001 Parameter: CNT_MAX, default 4, number of consecutive stable synchronized samples required to accept a level change; legal range 2..255.
REQ-002 Parameter: CNT_W, default 8, counter width; SHALL satisfy 2^CNT_W > CNT_MAX.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; 0 resets the block immediately, independent of clk.
REQ-005 Port: din  input  1  raw, asynchronous, possibly bouncing input (switch or button).
REQ-006 Port: q  output  1  debounced level; drives the d input of the downstream flip-flop stage.
REQ-007 Port: rise  output  1  one-cycle pulse when q goes 0->1.
REQ-008 Port: fall  output  1  one-cycle pulse when q goes 1->0.
REQ-009 Port: busy  output  1  high while a candidate level change is being qualified.

Function
REQ-010 din SHALL pass through a two-flop synchronizer (s1, s2); only s2 feeds the FSM.
REQ-011 FSM states SHALL be LOW, WAIT_HIGH, HIGH and WAIT_LOW, with an internal counter cnt.
REQ-012 In LOW with s2=1: go to WAIT_HIGH, cnt=1. In LOW with s2=0: stay, cnt=0.
REQ-013 In WAIT_HIGH with s2=0: go to LOW, cnt=0, no pulse.
REQ-014 In WAIT_HIGH with s2=1 and cnt<CNT_MAX-1: stay, cnt=cnt+1.
REQ-015 In WAIT_HIGH with s2=1 and cnt==CNT_MAX-1: go to HIGH, cnt=0, q=1, rise=1 on the same edge.
REQ-016 HIGH and WAIT_LOW SHALL mirror REQ-012..015 with s2 polarity inverted, ending in LOW with q=0 and fall=1.
REQ-017 rise and fall SHALL be registered, high for exactly one clk cycle, and never high simultaneously.
REQ-018 busy SHALL be 1 exactly when the state is WAIT_HIGH or WAIT_LOW.
REQ-019 Latency: for a clean din step held steady before clock edge 1, q and the pulse SHALL update at edge CNT_MAX+2 (edge 6 at default).
REQ-020 Any disagreeing s2 sample during a WAIT state SHALL abort qualification; the next agreeing sample SHALL restart the count from 1.
REQ-021 q SHALL change only on WAIT->LOW/HIGH transitions; q SHALL be constant in every other state.
REQ-022 cnt SHALL never exceed CNT_MAX-1, and it SHALL never wrap.

Reset
REQ-023 While reset=0: s1=s2=0, state=LOW, cnt=0, q=0, rise=0, fall=0, busy=0, taking effect asynchronously.
REQ-024 Reset asserted mid-qualification SHALL discard the pending change; no pulse SHALL be emitted for it.
REQ-025 After reset release with din=1, the block SHALL qualify normally and produce one rise at edge CNT_MAX+2 after release.

Verification (CNT_MAX=4, 10 ns clk)
REQ-026 reset=0, din=1 for 3 cycles -> q, rise, fall and busy stay 0 throughout; after release, rise is pulsed once at the 6th edge and q=1.
REQ-027 Clean step with q=0, din 0->1 held -> busy=1 from edge 3 to edge 5; at edge 6 q=1 and rise=1 for one cycle; fall stays 0.
REQ-028 Glitch: din=1 for 2 cycles, then 0 -> q stays 0, no rise or fall, busy returns to 0.
REQ-029 Bounce with q=1: din toggles 1/0/1/0 at one-cycle spacing, then holds 0 -> exactly one fall, at the 6th edge after the final transition; q=0.
REQ-030 reset driven 0 mid-clock while in WAIT_HIGH (cnt=2) -> busy and cnt clear immediately; after release with din=0 there is no rise and q=0.
REQ-031 Each scenario SHALL check that rise and fall are never high together and that each pulse lasts exactly one cycle.

Source files
------------

// File: rtl/debounce_edge_detect.sv
// Debouncer with rise/fall pulse outputs. The raw input is synchronized, and a
// level change is accepted only after CNT_MAX consecutive agreeing samples.

module debounce_edge_detect_chk #(
  parameter int CNT_MAX = 4,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             reset,
  input logic             q,
  input logic             rise,
  input logic             fall,
  input logic             busy,
  input logic             in_wait,
  input logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  a_no_overlap : assert property (@(posedge clk) disable iff (!reset) !(rise && fall));
  a_rise_once  : assert property (@(posedge clk) disable iff (!reset) rise |=> !rise);
  a_fall_once  : assert property (@(posedge clk) disable iff (!reset) fall |=> !fall);
  a_rise_q     : assert property (@(posedge clk) disable iff (!reset) rise |-> q);
  a_fall_q     : assert property (@(posedge clk) disable iff (!reset) fall |-> !q);
  a_cnt_max    : assert property (@(posedge clk) disable iff (!reset) cnt <= CNT_LAST);
  a_busy_wait  : assert property (@(posedge clk) disable iff (!reset) busy == in_wait);

endmodule

module debounce_edge_detect #(
  parameter int CNT_MAX = 4,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             s1_r;
  logic             s2_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             q_r;
  logic             rise_r;
  logic             fall_r;
  logic             busy_r;
  logic             in_wait_s;

  // Two-flop synchronizer for the asynchronous raw input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
    end
  end

  // Qualification FSM; all outputs are registered alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= LOW;
      cnt_r   <= CNT_ZERO;
      q_r     <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      case (state_r)
        LOW: begin
          if (s2_r) begin
            state_r <= WAIT_HIGH;
            cnt_r   <= CNT_ONE;
            busy_r  <= 1'b1;
          end else begin
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          if (!s2_r) begin
            state_r <= LOW;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
          end else if (cnt_r >= CNT_LAST) begin
            state_r <= HIGH;
            cnt_r   <= CNT_ZERO;
            q_r     <= 1'b1;
            rise_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            busy_r  <= 1'b1;
          end
        end
        HIGH: begin
          if (!s2_r) begin
            state_r <= WAIT_LOW;
            cnt_r   <= CNT_ONE;
            busy_r  <= 1'b1;
          end else begin
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (s2_r) begin
            state_r <= HIGH;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
          end else if (cnt_r >= CNT_LAST) begin
            state_r <= LOW;
            cnt_r   <= CNT_ZERO;
            q_r     <= 1'b0;
            fall_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= LOW;
          cnt_r   <= CNT_ZERO;
          q_r     <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_wait_s = (state_r == WAIT_HIGH) || (state_r == WAIT_LOW);

  assign q    = q_r;
  assign rise = rise_r;
  assign fall = fall_r;
  assign busy = busy_r;

  debounce_edge_detect_chk #(
    .CNT_MAX(CNT_MAX),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk    (clk),
    .reset  (reset),
    .q      (q_r),
    .rise   (rise_r),
    .fall   (fall_r),
    .busy   (busy_r),
    .in_wait(in_wait_s),
    .cnt    (cnt_r)
  );

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect at CNT_MAX=4; expected outputs are
// hand-derived per clock edge as {q, rise, fall, busy}.

module tb_debounce_edge_detect;

  logic clk;
  logic reset;
  logic din;
  logic q;
  logic rise;
  logic fall;
  logic busy;

  int checks   = 0;
  int failures = 0;

  int rise_total = 0;
  int fall_total = 0;
  int overlap    = 0;
  int long_pulse = 0;
  logic prev_rise = 1'b0;
  logic prev_fall = 1'b0;

  debounce_edge_detect #(.CNT_MAX(4), .CNT_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts pulses, overlaps and pulses longer than one cycle
  always begin
    @(posedge clk);
    #1;
    if (rise) rise_total++;
    if (fall) fall_total++;
    if (rise && fall) overlap++;
    if ((rise && prev_rise) || (fall && prev_fall)) long_pulse++;
    prev_rise = rise;
    prev_fall = fall;
  end

  initial begin
    #200us;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={q,rise,fall,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] exp);
    tick();
    check4(tag, {q, rise, fall, busy}, exp);
  endtask

  int r0;
  int f0;

  initial begin
    reset = 1'b0;
    din   = 1'b0;
    #1;
    check4("reset_async_initial", {q, rise, fall, busy}, 4'b0000);

    // Held in reset with din high: nothing may move
    din = 1'b1;
    for (int i = 1; i <= 3; i++) step($sformatf("in_reset_c%0d", i), 4'b0000);
    checkn("in_reset_sync", int'({dut.s1_r, dut.s2_r}), 0);

    // Release with din=1: rise at 6th edge after release
    r0 = rise_total;
    reset = 1'b1;
    step("rel_e1", 4'b0000);
    step("rel_e2", 4'b0000);
    step("rel_e3", 4'b0001);
    step("rel_e4", 4'b0001);
    step("rel_e5", 4'b0001);
    step("rel_e6", 4'b1100);
    step("rel_e7", 4'b1000);
    checkn("rel_rise_count", rise_total - r0, 1);

    // Bounce from q=1, final 1->0 transition then held low
    f0 = fall_total;
    din = 1'b0; step("bnc_e1", 4'b1000);
    din = 1'b1; step("bnc_e2", 4'b1000);
    din = 1'b0;
    step("bnc_f1", 4'b1001);
    step("bnc_f2", 4'b1000);
    step("bnc_f3", 4'b1001);
    step("bnc_f4", 4'b1001);
    step("bnc_f5", 4'b1001);
    step("bnc_f6", 4'b0010);
    step("bnc_f7", 4'b0000);
    checkn("bnc_fall_count", fall_total - f0, 1);

    // Two-cycle glitch from q=0 must be rejected
    r0 = rise_total;
    f0 = fall_total;
    din = 1'b1; step("gl_e1", 4'b0000);
    step("gl_e2", 4'b0000);
    din = 1'b0;
    step("gl_e3", 4'b0001);
    step("gl_e4", 4'b0001);
    step("gl_e5", 4'b0000);
    step("gl_e6", 4'b0000);
    checkn("gl_pulse_count", (rise_total - r0) + (fall_total - f0), 0);

    // Clean 0->1 step
    f0 = fall_total;
    din = 1'b1;
    step("st_e1", 4'b0000);
    step("st_e2", 4'b0000);
    step("st_e3", 4'b0001);
    step("st_e4", 4'b0001);
    step("st_e5", 4'b0001);
    step("st_e6", 4'b1100);
    step("st_e7", 4'b1000);
    step("st_e8", 4'b1000);
    checkn("st_no_fall", fall_total - f0, 0);

    // Return to low for the reset-abort scenario
    din = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    step("ret_e6", 4'b0010);
    step("ret_e7", 4'b0000);

    // Async reset in the middle of WAIT_HIGH with cnt=2
    r0 = rise_total;
    din = 1'b1;
    step("ra_e1", 4'b0000);
    step("ra_e2", 4'b0000);
    step("ra_e3", 4'b0001);
    step("ra_e4", 4'b0001);
    checkn("ra_cnt_before", int'(dut.cnt_r), 2);
    #2;
    reset = 1'b0;
    #1;
    check4("ra_async_clear", {q, rise, fall, busy}, 4'b0000);
    checkn("ra_cnt_cleared", int'(dut.cnt_r), 0);
    din = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) step($sformatf("ra_post_e%0d", i), 4'b0000);
    checkn("ra_no_rise", rise_total - r0, 0);

    checkn("pulse_overlap", overlap, 0);
    checkn("pulse_length", long_pulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
